// File: rtl/median_feeder.sv
// Sample sequencer for a sliding-window median filter. Clears the filter
// window, then loads each frame with edge replication (S0, S0, S1..S(N-1),
// S(N-1)). Every load uses a fixed-length slot so OUT_DATA is settled before
// LOAD rises and stays held for LOAD_GAP cycles after it falls.
module median_feeder #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned LOAD_GAP = 1
) (
  input  logic              CLK,
  input  logic              HARD_RESET,
  input  logic              START,
  input  logic [LEN_W-1:0]  FRAME_LEN,
  input  logic [DATA_W-1:0] SRC_DATA,
  input  logic              SRC_VALID,
  output logic              SRC_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              LOAD,
  output logic              RST,
  output logic              BUSY,
  output logic              DONE
);

  // Slot counter starts at LOAD_GAP+1 on issue and counts down to 0; the
  // cycle it reads 0 is the last slot cycle, so a new load may issue then.
  localparam int unsigned SLOT_W = 5;
  localparam logic [SLOT_W-1:0] SLOT_TOP = SLOT_W'(LOAD_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FIRST, PRIME, RUN, FLUSH, FIN
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cnt_inc;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               flush_q, flush_d;
  logic [DATA_W-1:0]  out_d;
  logic               ready_d;
  logic               accept;
  logic               slot_free;
  logic               issue;

  // Next-state, load-slot scheduling and next values of registered outputs.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    flush_d   = flush_q;
    out_d     = OUT_DATA;
    issue     = 1'b0;
    accept    = SRC_VALID && SRC_READY;
    slot_free = (slot_q == '0);
    cnt_inc   = cnt_q + LEN_W'(1);
    slot_d    = slot_free ? '0 : slot_q - SLOT_W'(1);

    case (state_q)
      IDLE: begin
        if (START) begin
          len_d   = FRAME_LEN;
          cnt_d   = '0;
          flush_d = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (len_q == '0) ? FIN : FIRST;
      end
      FIRST: begin
        if (accept) begin
          out_d   = SRC_DATA;
          issue   = 1'b1;
          cnt_d   = LEN_W'(1);
          state_d = PRIME;
        end
      end
      PRIME: begin
        // Replicate S0 as the leading edge sample; OUT_DATA still holds it.
        if (slot_free) begin
          issue   = 1'b1;
          state_d = (len_q == LEN_W'(1)) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          out_d = SRC_DATA;
          issue = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Replicate the last sample, then let its slot drain before finishing.
        if (slot_free) begin
          if (!flush_q) begin
            issue   = 1'b1;
            flush_d = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      slot_d = SLOT_TOP;
    end

    ready_d = ((state_d == FIRST) || (state_d == RUN)) && (slot_d == '0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK or posedge HARD_RESET) begin
    if (HARD_RESET) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      slot_q    <= '0;
      flush_q   <= 1'b0;
      OUT_DATA  <= '0;
      LOAD      <= 1'b0;
      RST       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      SRC_READY <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      flush_q   <= flush_d;
      OUT_DATA  <= out_d;
      LOAD      <= (slot_q == SLOT_TOP);
      RST       <= (state_d == CLEAR);
      BUSY      <= (state_d != IDLE) && (state_d != FIN);
      DONE      <= (state_d == FIN);
      SRC_READY <= ready_d;
    end
  end

endmodule

// File: tb/tb_median_feeder.sv
// Directed bench for median_feeder: one instance with LOAD_GAP=1 and one
// with LOAD_GAP=4, each observed by a per-cycle monitor of the load protocol.
module tb_median_feeder;

  logic        clk = 1'b0;
  logic        hard_rst;
  logic        start1, start4;
  logic [11:0] frame_len;
  logic [15:0] src_data;
  logic        src_valid;
  logic [1:0]  rdy, ld, rs, bsy, dn;
  logic [15:0] od0, od1;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;

  int gap[2]          = '{1, 4};
  int nload[2]        = '{0, 0};
  int rst_cnt[2]      = '{0, 0};
  int done_cnt[2]     = '{0, 0};
  int rdy_cnt[2]      = '{0, 0};
  int viol[2]         = '{0, 0};
  int hold[2]         = '{0, 0};
  int last_rst_cyc[2] = '{-100, -100};
  int last_done_cyc[2] = '{-100, -100};
  logic        prev_ld[2];
  logic [15:0] prev_od[2];
  logic [15:0] hval[2];
  int load_val[2][128];
  int load_cyc[2][128];

  int smp[8];
  int expv[8];

  always #5 clk = ~clk;

  median_feeder #(.DATA_W(16), .LEN_W(12), .LOAD_GAP(1)) dut (
    .CLK(clk), .HARD_RESET(hard_rst), .START(start1), .FRAME_LEN(frame_len),
    .SRC_DATA(src_data), .SRC_VALID(src_valid), .SRC_READY(rdy[0]),
    .OUT_DATA(od0), .LOAD(ld[0]), .RST(rs[0]), .BUSY(bsy[0]), .DONE(dn[0])
  );

  median_feeder #(.DATA_W(16), .LEN_W(12), .LOAD_GAP(4)) dut4 (
    .CLK(clk), .HARD_RESET(hard_rst), .START(start4), .FRAME_LEN(frame_len),
    .SRC_DATA(src_data), .SRC_VALID(src_valid), .SRC_READY(rdy[1]),
    .OUT_DATA(od1), .LOAD(ld[1]), .RST(rs[1]), .BUSY(bsy[1]), .DONE(dn[1])
  );

  // Per-cycle protocol monitor: records loads and counts protocol violations.
  always @(negedge clk) begin
    logic [15:0] cur;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      cur = (i == 0) ? od0 : od1;
      if (hard_rst) begin
        hold[i] = 0;
      end else begin
        if (ld[i]) begin
          load_val[i][nload[i] % 128] = int'(cur);
          load_cyc[i][nload[i] % 128] = cyc;
          nload[i]++;
          if (prev_ld[i]) viol[i]++;
          if (cur !== prev_od[i]) viol[i]++;
          if (cyc - last_rst_cyc[i] < 3) viol[i]++;
          hold[i] = gap[i];
          hval[i] = cur;
        end else if (hold[i] > 0) begin
          if (cur !== hval[i]) viol[i]++;
          hold[i]--;
        end
        if (ld[i] && rs[i]) viol[i]++;
        if (rdy[i] && (ld[i] || !bsy[i])) viol[i]++;
        if (rs[i]) begin rst_cnt[i]++; last_rst_cyc[i] = cyc; end
        if (dn[i]) begin done_cnt[i]++; last_done_cyc[i] = cyc; end
        if (rdy[i]) rdy_cnt[i]++;
      end
      prev_ld[i] = ld[i];
      prev_od[i] = cur;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input int sel, input int n);
    @(negedge clk);
    frame_len = 12'(n);
    if (sel == 0) start1 = 1'b1; else start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Offer smp[0..cnt-1]; before index stall_k hold SRC_VALID low 5 ready cycles.
  task automatic send(input int sel, input int cnt, input int stall_k);
    int t;
    int snap;
    int hi;
    for (int k = 0; k < cnt; k++) begin
      if (k == stall_k) begin
        src_valid = 1'b0;
        t = 0;
        while (!rdy[sel] && t < 100) begin @(negedge clk); t++; end
        snap = nload[sel];
        hi = 0;
        repeat (5) begin @(negedge clk); if (rdy[sel]) hi++; end
        chk("stall_ready_cycles", hi, 5);
        chk("stall_no_load", nload[sel] - snap, 0);
      end
      src_data  = 16'(smp[k]);
      src_valid = 1'b1;
      t = 0;
      while (!rdy[sel] && t < 100) begin @(negedge clk); t++; end
      chk("ready_timeout", int'(t >= 100), 0);
      @(negedge clk);
    end
    src_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel);
    int t;
    t = 0;
    while (!dn[sel] && t < 300) begin @(negedge clk); t++; end
    chk("done_timeout", int'(t >= 300), 0);
    @(negedge clk);
  endtask

  task automatic chk_loads(input int sel, input int base, input int n);
    for (int k = 0; k < n; k++)
      chk($sformatf("load_val[%0d]", k), load_val[sel][(base + k) % 128], expv[k]);
  endtask

  task automatic chk_period(input int sel, input int base, input int n, input int per);
    int bad;
    bad = 0;
    for (int k = 1; k < n; k++)
      if (load_cyc[sel][(base + k) % 128] - load_cyc[sel][(base + k - 1) % 128] != per) bad++;
    chk("load_period_errors", bad, 0);
  endtask

  initial begin
    int b, rb, db, vb, qb, t;
    hard_rst  = 1'b1;
    start1    = 1'b0;
    start4    = 1'b0;
    frame_len = '0;
    src_data  = '0;
    src_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", int'({ld[0], rs[0], bsy[0], dn[0], rdy[0]}), 0);
    chk("reset_out_data", int'(od0), 0);
    hard_rst = 1'b0;
    repeat (2) @(negedge clk);

    // N=4, always-valid samples
    b = nload[0]; rb = rst_cnt[0]; db = done_cnt[0]; vb = viol[0];
    smp  = '{10, 30, 20, 40, 0, 0, 0, 0};
    expv = '{10, 10, 30, 20, 40, 40, 0, 0};
    start_frame(0, 4);
    chk("busy_after_start", int'(bsy[0]), 1);
    send(0, 4, -1);
    wait_done(0);
    chk("n4_load_count", nload[0] - b, 6);
    chk_loads(0, b, 6);
    chk_period(0, b, 6, 3);
    chk("n4_rst_pulses", rst_cnt[0] - rb, 1);
    chk("n4_done_pulses", done_cnt[0] - db, 1);
    chk("n4_busy_after", int'(bsy[0]), 0);
    chk("n4_protocol_viol", viol[0] - vb, 0);

    // N=0: clear then done, no loads, never ready
    b = nload[0]; rb = rst_cnt[0]; db = done_cnt[0]; qb = rdy_cnt[0];
    start_frame(0, 0);
    wait_done(0);
    chk("n0_rst_pulses", rst_cnt[0] - rb, 1);
    chk("n0_load_count", nload[0] - b, 0);
    chk("n0_ready_cycles", rdy_cnt[0] - qb, 0);
    chk("n0_done_delay", last_done_cyc[0] - last_rst_cyc[0], 1);
    chk("n0_done_pulses", done_cnt[0] - db, 1);

    // N=1, sample 0x7FFF replicated three times
    b = nload[0];
    smp  = '{32'h7FFF, 0, 0, 0, 0, 0, 0, 0};
    expv = '{32'h7FFF, 32'h7FFF, 32'h7FFF, 0, 0, 0, 0, 0};
    start_frame(0, 1);
    send(0, 1, -1);
    wait_done(0);
    chk("n1_load_count", nload[0] - b, 3);
    chk_loads(0, b, 3);

    // N=3 with a 5-cycle valid gap before the third sample
    b = nload[0]; vb = viol[0];
    smp  = '{100, 200, 300, 0, 0, 0, 0, 0};
    expv = '{100, 100, 200, 300, 300, 0, 0, 0};
    start_frame(0, 3);
    send(0, 3, 2);
    wait_done(0);
    chk("stall_load_count", nload[0] - b, 5);
    chk_loads(0, b, 5);
    chk("stall_protocol_viol", viol[0] - vb, 0);

    // Abort an N=8 frame right after its second LOAD
    b = nload[0]; db = done_cnt[0];
    smp = '{32'h0ABC, 0, 0, 0, 0, 0, 0, 0};
    start_frame(0, 8);
    send(0, 1, -1);
    t = 0;
    while (nload[0] - b < 2 && t < 100) begin @(negedge clk); t++; end
    chk("abort_wait_timeout", int'(t >= 100), 0);
    chk("abort_busy_before", int'(bsy[0]), 1);
    @(posedge clk);
    #2 hard_rst = 1'b1;
    #1;
    chk("abort_ctrl", int'({ld[0], rs[0], bsy[0], dn[0], rdy[0]}), 0);
    chk("abort_out_data", int'(od0), 0);
    repeat (2) @(negedge clk);
    hard_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt[0] - db, 0);
    chk("abort_stays_idle", int'(bsy[0]), 0);

    // Fresh N=2 frame after the abort
    b = nload[0]; db = done_cnt[0];
    smp  = '{32'h1234, 32'h0055, 0, 0, 0, 0, 0, 0};
    expv = '{32'h1234, 32'h1234, 32'h0055, 32'h0055, 0, 0, 0, 0};
    start_frame(0, 2);
    send(0, 2, -1);
    wait_done(0);
    chk("n2_load_count", nload[0] - b, 4);
    chk_loads(0, b, 4);
    chk("n2_done_pulses", done_cnt[0] - db, 1);

    // LOAD_GAP=4 instance, second START while busy must be ignored
    b = nload[1]; rb = rst_cnt[1]; db = done_cnt[1]; vb = viol[1];
    smp  = '{1, 2, 3, 0, 0, 0, 0, 0};
    expv = '{1, 1, 2, 3, 3, 0, 0, 0};
    start_frame(1, 3);
    start_frame(1, 0);
    send(1, 3, -1);
    wait_done(1);
    chk("g4_load_count", nload[1] - b, 5);
    chk_loads(1, b, 5);
    chk_period(1, b, 5, 6);
    chk("g4_rst_pulses", rst_cnt[1] - rb, 1);
    chk("g4_done_pulses", done_cnt[1] - db, 1);
    chk("g4_protocol_viol", viol[1] - vb, 0);
    chk("g4_busy_after", int'(bsy[1]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
